// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receive-character valid/ready handshake between the UART receiver and its consumer
interface uart_rx_fifo_if #(parameter int DATA_MAX = 8);
  logic [DATA_MAX-1:0] rx_data;
  logic rx_perr;
  logic rx_ferr;
  logic rx_brk;
  logic rx_valid;
  logic rx_ready;
  modport master(output rx_data, rx_perr, rx_ferr, rx_brk, rx_valid, input rx_ready);
  modport slave(input rx_data, rx_perr, rx_ferr, rx_brk, rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: majority-vote UART receiver with runtime frame format feeding a first-word-fall-through FIFO
module uart_rx_fifo #(
  parameter int DATA_MAX   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] UART_CPB,
  input  logic [3:0]  data_bits,
  input  logic        parity_en,
  input  logic        parity_odd,
  input  logic        two_stop,
  input  logic        rx_serial,
  uart_rx_fifo_if.master rx,
  output logic        overrun,
  input  logic        ovr_clr,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int W  = DATA_MAX + 3;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE} state_t;
  state_t state, nxt;
  logic s1, s2, rxs_d;
  logic [15:0] cnt, cpb_l, mid;
  logic [3:0] db_l, bit_idx;
  logic pen_l, podd_l, two_l;
  logic v0, v1, vote, vote_cyc, start_det;
  logic [DATA_MAX-1:0] sh;
  logic px, allz, f1;
  logic push, wr, pop, full, empty;
  logic brk_e, ferr_e, perr_e;
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [W-1:0] head;
  logic [AW:0] wp, rp;
  assign mid       = cpb_l >> 1;
  assign vote_cyc  = cnt == mid + 16'd1;
  assign vote      = (v0 & v1) | (v0 & s2) | (v1 & s2);
  assign start_det = (state == IDLE) & rxs_d & ~s2;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (start_det) nxt = START;
      START:     if (vote_cyc) nxt = vote ? IDLE : DATA;
      DATA:      if (vote_cyc && bit_idx == db_l - 4'd1) nxt = pen_l ? PARITY : STOP1;
      PARITY:    if (vote_cyc) nxt = STOP1;
      STOP1:     if (vote_cyc) nxt = two_l ? STOP2 : (vote ? IDLE : WAIT_IDLE);
      STOP2:     if (vote_cyc) nxt = vote ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (s2) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    push = vote_cyc & (((state == STOP1) & ~two_l) | (state == STOP2));
    busy = state != IDLE;
  end
  // with two stop bits the first stop vote is already folded into allz
  assign brk_e  = (state == STOP2) ? allz : allz & ~vote;
  assign ferr_e = f1 | ~vote;
  assign perr_e = pen_l & (px ^ podd_l);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      rxs_d <= 1'b1;
      cnt <= '0;
      cpb_l <= '0;
      db_l <= '0;
      pen_l <= 1'b0;
      podd_l <= 1'b0;
      two_l <= 1'b0;
      v0 <= 1'b1;
      v1 <= 1'b1;
      bit_idx <= '0;
      sh <= '0;
      px <= 1'b0;
      allz <= 1'b1;
      f1 <= 1'b0;
    end else begin
      s1 <= rx_serial;
      s2 <= s1;
      rxs_d <= s2;
      if (start_det) begin
        cnt <= '0;
        cpb_l <= UART_CPB;
        db_l <= data_bits;
        pen_l <= parity_en;
        podd_l <= parity_odd;
        two_l <= two_stop;
        bit_idx <= '0;
        sh <= '0;
        px <= 1'b0;
        allz <= 1'b1;
        f1 <= 1'b0;
      end else cnt <= (cnt == cpb_l - 16'd1) ? '0 : cnt + 16'd1;
      if (cnt == mid - 16'd1) v0 <= s2;
      if (cnt == mid) v1 <= s2;
      if (vote_cyc) begin
        if (state == DATA) begin
          sh <= sh | (DATA_MAX'(vote) << bit_idx);
          bit_idx <= bit_idx + 4'd1;
        end
        if (state == DATA || state == PARITY) px <= px ^ vote;
        if (state == DATA || state == PARITY || state == STOP1) allz <= allz & ~vote;
        if (state == STOP1) f1 <= ~vote;
      end
    end
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) & (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = ~empty & rx.rx_ready;
  assign wr    = push & (~full | pop);
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= {brk_e, ferr_e, perr_e, sh};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      overrun <= (push & full & ~pop) | (overrun & ~ovr_clr);
    end
  assign head        = mem[rp[AW-1:0]];
  assign rx.rx_valid = ~empty;
  assign rx.rx_data  = empty ? '0 : head[DATA_MAX-1:0];
  assign rx.rx_perr  = ~empty & head[DATA_MAX];
  assign rx.rx_ferr  = ~empty & head[DATA_MAX+1];
  assign rx.rx_brk   = ~empty & head[DATA_MAX+2];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames at 16 clocks per bit with hand-computed expected characters and flags
module tb_uart_rx_fifo;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic [15:0] cpb = 16;
  logic [3:0] db = 8;
  logic pen = 0, podd = 0, two = 0, rxd = 1, clr = 0;
  logic ovr, busy;
  int errs = 0, checks = 0;
  time t0 = 0, t_rise = 0;
  logic vq = 0;
  logic [7:0] drain_exp [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
  uart_rx_fifo_if #(.DATA_MAX(8)) u();
  uart_rx_fifo #(.DATA_MAX(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .UART_CPB(cpb), .data_bits(db), .parity_en(pen),
    .parity_odd(podd), .two_stop(two), .rx_serial(rxd), .rx(u),
    .overrun(ovr), .ovr_clr(clr), .busy(busy));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (u.rx_valid && !vq) t_rise = $time;
    vq = u.rx_valid;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic bit_out(input logic b, input logic gl);
    for (int i = 0; i < 16; i++) begin
      rxd = (gl && i == 9) ? ~b : b;
      @(negedge clk);
    end
  endtask
  task automatic frame(input logic [7:0] d, input int nb, input logic pbit, input logic s2v, input int gb);
    bit_out(1'b0, 1'b0);
    for (int i = 0; i < nb; i++) bit_out(d[i], i == gb);
    if (pen) bit_out(pbit, 1'b0);
    bit_out(1'b1, 1'b0);
    if (two) bit_out(s2v, 1'b0);
    rxd = 1'b1;
  endtask
  task automatic pop();
    u.rx_ready = 1'b1;
    @(negedge clk);
    u.rx_ready = 1'b0;
  endtask
  initial begin
    u.rx_ready = 1'b0;
    tick(3);
    chk("rst_valid", u.rx_valid, 0);
    chk("rst_data", u.rx_data, 0);
    chk("rst_flags", {u.rx_brk, u.rx_ferr, u.rx_perr}, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_busy", busy, 0);
    rst = 1;
    tick(5);
    t0 = $time;
    frame(8'hA5, 8, 1'b0, 1'b1, -1);
    tick(10);
    chk("a5_latency", 32'((t_rise - t0) / 10), 157);
    chk("a5_data", u.rx_data, 8'hA5);
    chk("a5_flags", {u.rx_brk, u.rx_ferr, u.rx_perr}, 0);
    pop();
    chk("a5_single", u.rx_valid, 0);
    db = 7; pen = 1; podd = 0;
    frame(8'h41, 7, 1'b1, 1'b1, -1);
    tick(10);
    chk("7e1_bad_data", u.rx_data, 8'h41);
    chk("7e1_bad_perr", u.rx_perr, 1);
    chk("7e1_bad_ferr", u.rx_ferr, 0);
    pop();
    frame(8'h41, 7, 1'b0, 1'b1, -1);
    tick(10);
    chk("7e1_ok_data", u.rx_data, 8'h41);
    chk("7e1_ok_perr", u.rx_perr, 0);
    pop();
    db = 8; pen = 0; two = 1;
    frame(8'h5A, 8, 1'b0, 1'b0, -1);
    tick(40);
    chk("8n2_data", u.rx_data, 8'h5A);
    chk("8n2_flags", {u.rx_brk, u.rx_ferr, u.rx_perr}, 3'b010);
    pop();
    two = 0;
    rxd = 0;
    tick(320);
    chk("brk_valid", u.rx_valid, 1);
    chk("brk_data", u.rx_data, 0);
    chk("brk_flags", {u.rx_brk, u.rx_ferr, u.rx_perr}, 3'b110);
    chk("brk_busy", busy, 1);
    pop();
    tick(100);
    chk("brk_no_more_low", u.rx_valid, 0);
    rxd = 1;
    tick(40);
    chk("brk_no_more_high", u.rx_valid, 0);
    chk("brk_idle", busy, 0);
    rxd = 0;
    tick(3);
    rxd = 1;
    tick(40);
    chk("glitch_valid", u.rx_valid, 0);
    chk("glitch_busy", busy, 0);
    frame(8'h96, 8, 1'b0, 1'b1, 2);
    tick(10);
    chk("midglitch_data", u.rx_data, 8'h96);
    pop();
    frame(8'h11, 8, 1'b0, 1'b1, -1); tick(4);
    frame(8'h22, 8, 1'b0, 1'b1, -1); tick(4);
    frame(8'h33, 8, 1'b0, 1'b1, -1); tick(4);
    frame(8'h44, 8, 1'b0, 1'b1, -1); tick(4);
    chk("full_no_ovr", ovr, 0);
    frame(8'h55, 8, 1'b0, 1'b1, -1);
    tick(10);
    chk("ovr_set", ovr, 1);
    chk("ovr_head", u.rx_data, 8'h11);
    clr = 1;
    tick(1);
    clr = 0;
    chk("ovr_clr", ovr, 0);
    fork
      frame(8'h66, 8, 1'b0, 1'b1, -1);
      begin
        tick(156);
        u.rx_ready = 1'b1;
        tick(1);
        u.rx_ready = 1'b0;
      end
    join
    tick(10);
    chk("pushpop_no_ovr", ovr, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), u.rx_data, 32'(drain_exp[i]));
      pop();
    end
    chk("drain_empty", u.rx_valid, 0);
    frame(8'h77, 8, 1'b0, 1'b1, -1);
    tick(10);
    chk("pre_rst_valid", u.rx_valid, 1);
    bit_out(1'b0, 1'b0);
    bit_out(1'b1, 1'b0);
    bit_out(1'b0, 1'b0);
    bit_out(1'b1, 1'b0);
    rxd = 0;
    tick(8);
    rst = 0;
    rxd = 1;
    tick(2);
    chk("mrst_valid", u.rx_valid, 0);
    chk("mrst_data", u.rx_data, 0);
    chk("mrst_busy", busy, 0);
    rst = 1;
    tick(40);
    chk("mrst_after_valid", u.rx_valid, 0);
    frame(8'h3C, 8, 1'b0, 1'b1, -1);
    tick(10);
    chk("post_rst_valid", u.rx_valid, 1);
    chk("post_rst_data", u.rx_data, 8'h3C);
    chk("post_rst_flags", {u.rx_brk, u.rx_ferr, u.rx_perr}, 0);
    pop();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
